uart_ctrl_fifo: RTL
===================

// Module: uart_ctrl_fifo
// PURPOSE
//   Full-duplex UART controller with built-in RX and TX engines, configurable frame format, and RX/TX FIFOs.
//   Sits between the PC serial pins and the sorter datapath; successor to the fixed 8N1, unbuffered controller.
//   Adds parity, 2-stop-bit mode, buffering, and error reporting.
// PARAMETERS
//   DATA_BITS      8   data bits per frame, legal 5..9, sent LSB first
//   PARITY         0   0 = none, 1 = even, 2 = odd
//   STOP_BITS      1   TX stop bits, 1 or 2 (RX always checks exactly one)
//   RX_FIFO_DEPTH  16  entries, power of 2, >= 2
//   TX_FIFO_DEPTH  16  entries, power of 2, >= 2
// PORTS
//   clk           in   1          single clock domain
//   rst_n         in   1          synchronous, active-low reset
//   pc_data_o     out  DATA_BITS  RX FIFO head
//   pc_valid_o    out  1          RX FIFO not empty
//   pc_ready_i    in   1          pop RX FIFO when valid & ready
//   pc_data_i     in   DATA_BITS  TX write data
//   pc_valid_i    in   1          TX write request
//   pc_ready_o    out  1          TX FIFO not full
//   rxd           in   1          async serial input
//   txd           out  1          serial output, idle high
//   prescale      in   16         clk cycles per 1/8 bit; bit time = 8*max(prescale,1)
//   rx_frame_err  out  1          1-cycle pulse: stop bit sampled 0, byte dropped
//   rx_parity_err out  1          1-cycle pulse: parity mismatch, byte dropped
//   rx_overrun    out  1          1-cycle pulse: good byte, RX FIFO full, byte dropped
//   rx_busy       out  1          RX engine not IDLE
//   tx_busy       out  1          TX engine not IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at posedge)
//   - Both FIFOs are empty. FSMs go to IDLE. Any frame in progress is discarded.
//   - Output values during and after reset: txd=1, pc_valid_o=0, pc_ready_o=1, all pulse and busy outputs 0.
//   - The rxd synchroniser flops reset to 1.
//   Prescale
//   - prescale==0 is treated as 1.
//   - Each engine latches prescale at frame start; changes mid-frame have no effect on that frame.
//   RX path
//   - rxd passes through a 2-flop synchroniser.
//   - FSM: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
//   - IDLE -> START on a synchronised falling edge.
//   - START samples at 4*prescale cycles. If the sample is 1 it is a glitch: return to IDLE, no pulse.
//   - DATA, PARITY and STOP each sample every 8*prescale cycles, at mid-bit.
//   - At STOP, in priority order:
//     - stop sampled 0 -> rx_frame_err;
//     - else parity mismatch -> rx_parity_err;
//     - else FIFO full -> rx_overrun;
//     - else push the byte.
//   - Return to IDLE right after the stop sample, which allows back-to-back frames.
//   - A pushed byte is visible on pc_valid_o on the cycle after the push. No bypass.
//   TX path
//   - A write is accepted iff pc_valid_i & pc_ready_o. It lands in the FIFO the next cycle.
//   - FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE. The FIFO is popped on IDLE -> START.
//   - txd falls no later than 3 cycles after an accepted write into an empty FIFO with TX idle.
//   - Each bit lasts 8*prescale cycles. STOP lasts STOP_BITS bit times.
//   - With the FIFO non-empty, START follows STOP with no idle gap.
//   - pc_ready_o depends only on FIFO full; a same-cycle pop does not free space for that cycle's write.
//   - Parity bit = ^data for even, ~^data for odd.
//   FIFO
//   - Simultaneous push and pop when neither full nor empty: count unchanged, ordering preserved.
//   - A push into a full FIFO or a pop from an empty one is ignored.
// STRUCTURE
//   - uart_pkg holds the parity_e enum (PAR_NONE/PAR_EVEN/PAR_ODD), the rx_state_e/tx_state_e enums, and the MAX_DATA_BITS=9 constant.
//   - Sub-module uart_sync_fifo #(WIDTH, DEPTH) is instantiated twice.
//   - The RX and TX FSMs are inline in this module.
// TESTING  (prescale=2 -> 16 cycles/bit, DATA_BITS=8 unless stated)
//   1. PARITY=0: drive rxd frame 0xA5, pc_ready_i=0
//      -> pc_valid_o=1, pc_data_o=0xA5, no error pulses; pop once -> pc_valid_o=0.
//   2. Write 0x3C, 0xFF back-to-back, STOP_BITS=2
//      -> txd shows start, 00111100 LSB-first, 2 stop bits, then the next start with no gap; tx_busy falls after the last stop.
//   3. PARITY=1: rxd frame 0x07 with parity bit 0 -> rx_parity_err pulse, FIFO stays empty.
//      Then 0x07 with parity 1 -> byte accepted.
//   4. Frame with stop bit 0 -> rx_frame_err, no push.
//      A 1-bit-time-short low glitch (6 cycles) -> no pulse, rx_busy returns 0.
//   5. RX_FIFO_DEPTH=4: receive 5 frames with pc_ready_i=0
//      -> 4 stored in order, rx_overrun on the 5th; TX: 17 writes with TX_FIFO_DEPTH=16 and prescale large -> pc_ready_o=0 after FIFO full.
//   6. Assert rst_n=0 mid TX data bit and mid RX frame
//      -> txd=1 next cycle, FIFOs empty, busy=0; the next full frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART controller: frame-format enums,
// engine state encodings and the bit-timer helpers.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;
  localparam int BIT_CNT_W     = $clog2(MAX_DATA_BITS);
  localparam int TMR_W         = 20;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Zero-extending the data word leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] d, input parity_e mode);
    logic p;
    p = 1'b0;
    if (mode == PAR_EVEN) p = ^d;
    else if (mode == PAR_ODD) p = ~^d;
    return p;
  endfunction

  // Terminal-count reload: (prescale << sh) cycles, counted down to zero.
  function automatic logic [TMR_W-1:0] ticks(input logic [15:0] ps, input int unsigned sh);
    return (TMR_W'(ps) << sh) - TMR_W'(1);
  endfunction

endpackage

// File: rtl/uart_ctrl_fifo_if.sv
// Parallel-side handshake bundle between the UART controller and the PC/sorter datapath.
// Signal suffixes are from the controller's point of view.
interface uart_ctrl_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] pc_data_o;
  logic                 pc_valid_o;
  logic                 pc_ready_i;
  logic [DATA_BITS-1:0] pc_data_i;
  logic                 pc_valid_i;
  logic                 pc_ready_o;

  modport slave (
    output pc_data_o, pc_valid_o, pc_ready_o,
    input  pc_ready_i, pc_data_i, pc_valid_i
  );

  modport master (
    input  pc_data_o, pc_valid_o, pc_ready_o,
    output pc_ready_i, pc_data_i, pc_valid_i
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; push when full and pop when empty are ignored.
// Read data is the combinational head entry.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_ctrl_fifo.sv
// Full-duplex buffered UART: oversampling RX engine and TX engine with configurable
// data width, parity and stop bits, each backed by a sync FIFO.
//
// state     | meaning
// IDLE      | RX: wait for synchronised falling edge / TX: wait for FIFO data
// START     | RX: wait to mid start bit, reject glitches / TX: drive start bit
// DATA      | shift DATA_BITS bits, LSB first
// PARITY    | parity bit (only when PARITY != 0)
// STOP      | RX: sample one stop bit, report/push / TX: STOP_BITS bit times high
module uart_ctrl_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 16,
  parameter int TX_FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_ctrl_fifo_if.slave pc,
  input  logic            rxd,
  output logic            txd,
  input  logic [15:0]     prescale,
  output logic            rx_frame_err,
  output logic            rx_parity_err,
  output logic            rx_overrun,
  output logic            rx_busy,
  output logic            tx_busy
);

  localparam parity_e PAR_MODE = (PARITY == 1) ? PAR_EVEN :
                                 (PARITY == 2) ? PAR_ODD  : PAR_NONE;
  localparam int unsigned STOP_SH = (STOP_BITS == 2) ? 4 : 3;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  logic [15:0] eff_ps;
  assign eff_ps = (prescale == 16'd0) ? 16'd1 : prescale;

  // ---------------- RX ----------------
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [TMR_W-1:0]     rx_tmr_q, rx_tmr_d;
  logic [15:0]          rx_ps_q, rx_ps_d;
  logic [BIT_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ovr_q, rx_ovr_d;
  logic                 rx_push, rx_empty, rx_full;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tmr_d   = (rx_tmr_q != '0) ? rx_tmr_q - 1'b1 : rx_tmr_q;
    rx_ps_d    = rx_ps_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shreg_d = rx_shreg_q;
    rx_par_d   = rx_par_q;
    rx_ferr_d  = 1'b0;
    rx_perr_d  = 1'b0;
    rx_ovr_d   = 1'b0;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_ps_d    = eff_ps;
          rx_tmr_d   = ticks(eff_ps, 2);
        end
      end
      RX_START: begin
        if (rx_tmr_q == '0) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = '0;
            rx_tmr_d   = ticks(rx_ps_q, 3);
          end
        end
      end
      RX_DATA: begin
        if (rx_tmr_q == '0) begin
          rx_shreg_d = {rx_sync_q, rx_shreg_q[DATA_BITS-1:1]};
          rx_tmr_d   = ticks(rx_ps_q, 3);
          if (rx_cnt_q == LAST_BIT)
            rx_state_d = (PAR_MODE == PAR_NONE) ? RX_STOP : RX_PARITY;
          else
            rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (rx_tmr_q == '0) begin
          rx_par_d   = rx_sync_q;
          rx_state_d = RX_STOP;
          rx_tmr_d   = ticks(rx_ps_q, 3);
        end
      end
      RX_STOP: begin
        if (rx_tmr_q == '0) begin
          rx_state_d = RX_IDLE;
          if (!rx_sync_q)
            rx_ferr_d = 1'b1;
          else if (PAR_MODE != PAR_NONE &&
                   rx_par_q != calc_parity(MAX_DATA_BITS'(rx_shreg_q), PAR_MODE))
            rx_perr_d = 1'b1;
          else if (rx_full)
            rx_ovr_d = 1'b1;
          else
            rx_push = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Synchroniser and edge-detect flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tmr_q   <= '0;
      rx_ps_q    <= 16'd1;
      rx_cnt_q   <= '0;
      rx_shreg_q <= '0;
      rx_par_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_meta_q  <= rxd;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_ps_q    <= rx_ps_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shreg_q <= rx_shreg_d;
      rx_par_q   <= rx_par_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_perr_q  <= rx_perr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .wdata_i (rx_shreg_q),
    .pop_i   (~rx_empty & pc.pc_ready_i),
    .rdata_o (pc.pc_data_o),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  assign pc.pc_valid_o = ~rx_empty;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_overrun    = rx_ovr_q;
  assign rx_busy       = (rx_state_q != RX_IDLE);

  // ---------------- TX ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [TMR_W-1:0]     tx_tmr_q, tx_tmr_d;
  logic [15:0]          tx_ps_q, tx_ps_d;
  logic [BIT_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
  logic                 tx_par_q, tx_par_d;
  logic                 txd_q, txd_d;
  logic                 tx_pop, tx_empty, tx_full;
  logic [DATA_BITS-1:0] tx_head;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = (tx_tmr_q != '0) ? tx_tmr_q - 1'b1 : tx_tmr_q;
    tx_ps_d    = tx_ps_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shreg_d = tx_shreg_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_state_d = TX_START;
          tx_pop     = 1'b1;
          tx_shreg_d = tx_head;
          tx_par_d   = calc_parity(MAX_DATA_BITS'(tx_head), PAR_MODE);
          tx_ps_d    = eff_ps;
          tx_tmr_d   = ticks(eff_ps, 3);
        end
      end
      TX_START: begin
        if (tx_tmr_q == '0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_tmr_d   = ticks(tx_ps_q, 3);
        end
      end
      TX_DATA: begin
        if (tx_tmr_q == '0) begin
          if (tx_cnt_q == LAST_BIT) begin
            if (PAR_MODE == PAR_NONE) begin
              tx_state_d = TX_STOP;
              tx_tmr_d   = ticks(tx_ps_q, STOP_SH);
            end else begin
              tx_state_d = TX_PARITY;
              tx_tmr_d   = ticks(tx_ps_q, 3);
            end
          end else begin
            tx_cnt_d   = tx_cnt_q + 1'b1;
            tx_shreg_d = tx_shreg_q >> 1;
            tx_tmr_d   = ticks(tx_ps_q, 3);
          end
        end
      end
      TX_PARITY: begin
        if (tx_tmr_q == '0) begin
          tx_state_d = TX_STOP;
          tx_tmr_d   = ticks(tx_ps_q, STOP_SH);
        end
      end
      TX_STOP: begin
        if (tx_tmr_q == '0) begin
          // Next frame starts straight out of STOP so queued bytes go out gap-free.
          if (!tx_empty) begin
            tx_state_d = TX_START;
            tx_pop     = 1'b1;
            tx_shreg_d = tx_head;
            tx_par_d   = calc_parity(MAX_DATA_BITS'(tx_head), PAR_MODE);
            tx_ps_d    = eff_ps;
            tx_tmr_d   = ticks(eff_ps, 3);
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    case (tx_state_d)
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = tx_shreg_d[0];
      TX_PARITY: txd_d = tx_par_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_tmr_q   <= '0;
      tx_ps_q    <= 16'd1;
      tx_cnt_q   <= '0;
      tx_shreg_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_ps_q    <= tx_ps_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shreg_q <= tx_shreg_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
    end
  end

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (pc.pc_valid_i & ~tx_full),
    .wdata_i (pc.pc_data_i),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  assign pc.pc_ready_o = ~tx_full;
  assign txd           = txd_q;
  assign tx_busy       = (tx_state_q != TX_IDLE);

endmodule
